mux_scan_sequencer: RTL



---
 rtl/mux_scan_sequencer.sv | 96 +++++++++
 1 files changed

// File: rtl/mux_scan_sequencer.sv
// ============================================================================
// Module   : mux_scan_sequencer
// Purpose  : Steps 4:1 mux selects through channels 0..3 and packs captured y into a word.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mux_scan_sequencer #(
  parameter int DWELL = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       continuous,
  input  logic       y,
  output logic       s1,
  output logic       s0,
  output logic [3:0] sample,
  output logic       valid,
  output logic       changed,
  output logic       busy
);

  localparam int            CW   = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t          r_state;
  logic [1:0]      r_ch;
  logic [CW-1:0]   r_dcnt;
  logic [2:0]      r_shadow;
  logic [3:0]      w_word;

  // Channel 3 is never shadowed: it goes straight into the word with the other three.
  assign w_word = {y, r_shadow};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_ch     <= 2'd0;
      r_dcnt   <= '0;
      r_shadow <= 3'b000;
      s1       <= 1'b0;
      s0       <= 1'b0;
      sample   <= 4'b0000;
      valid    <= 1'b0;
      changed  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      valid   <= 1'b0;
      changed <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= SCAN;
            r_ch    <= 2'd0;
            r_dcnt  <= '0;
            s1      <= 1'b0;
            s0      <= 1'b0;
            busy    <= 1'b1;
          end
        end
        SCAN: begin
          if (r_dcnt != LAST) begin
            r_dcnt <= r_dcnt + 1'b1;
          end else begin
            r_dcnt <= '0;
            if (r_ch != 2'd3) begin
              r_shadow[r_ch] <= y;
              r_ch           <= r_ch + 2'd1;
              {s1, s0}       <= r_ch + 2'd1;
            end else begin
              sample   <= w_word;
              valid    <= 1'b1;
              changed  <= (w_word != sample);
              r_ch     <= 2'd0;
              {s1, s0} <= 2'b00;
              if (!continuous) begin
                r_state <= IDLE;
                busy    <= 1'b0;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
